period_meter: RTL



---
 rtl/period_meter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/period_meter.sv
// Period / high-time meter: times a slow asynchronous input against CLK between two rising edges.
// Define PERIOD_METER_CONTINUOUS_EN for back-to-back measurement after a single START.
//
// state | meaning
// IDLE  | waiting for START
// ARMED | waiting for the first rising edge, timeout running
// MEAS  | counting period and high time until the next rising edge
// DONE  | one-cycle result slot (VALID), then back to IDLE
module period_meter #(
    parameter int CNT_W       = 28,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_CYCLES  = 134217727
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             SIG_IN,
    input  logic             START,
    output logic             BUSY,
    output logic             VALID,
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] HIGH_TIME,
    output logic             TIMED_OUT
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] MEAS  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q, s_d_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hcnt_q, hcnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_q, high_d;
    logic                   timed_out_q, timed_out_d;
    logic                   valid_q, valid_d;
    logic                   s;
    logic                   rise;

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], SIG_IN};
        s           = sync_q[SYNC_STAGES-1];
        s_d_d       = s;
        rise        = s & ~s_d_q;

        state_d     = state_q;
        cnt_d       = cnt_q;
        hcnt_d      = hcnt_q;
        period_d    = period_q;
        high_d      = high_q;
        timed_out_d = timed_out_q;
        valid_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // a rising edge coinciding with START is deliberately not used
                if (START) begin
                    cnt_d   = '0;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (rise) begin
                    cnt_d   = ONE;
                    hcnt_d  = ONE;
                    state_d = MEAS;
                end else if (cnt_q == MAX_C) begin
                    period_d    = '0;
                    high_d      = '0;
                    timed_out_d = 1'b1;
                    valid_d     = 1'b1;
                    cnt_d       = '0;
`ifdef PERIOD_METER_CONTINUOUS_EN
                    state_d     = ARMED;
`else
                    state_d     = DONE;
`endif
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            MEAS: begin
                // the edge takes priority over a timeout in the same cycle
                if (rise) begin
                    period_d    = cnt_q;
                    high_d      = hcnt_q;
                    timed_out_d = 1'b0;
                    valid_d     = 1'b1;
`ifdef PERIOD_METER_CONTINUOUS_EN
                    cnt_d       = ONE;
                    hcnt_d      = ONE;
`else
                    state_d     = DONE;
`endif
                end else if (cnt_q == MAX_C) begin
                    period_d    = '0;
                    high_d      = '0;
                    timed_out_d = 1'b1;
                    valid_d     = 1'b1;
                    cnt_d       = '0;
`ifdef PERIOD_METER_CONTINUOUS_EN
                    state_d     = ARMED;
`else
                    state_d     = DONE;
`endif
                end else begin
                    cnt_d  = cnt_q + ONE;
                    hcnt_d = hcnt_q + CNT_W'(s);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync_q      <= '0;
            s_d_q       <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            period_q    <= '0;
            high_q      <= '0;
            timed_out_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            s_d_q       <= s_d_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            period_q    <= period_d;
            high_q      <= high_d;
            timed_out_q <= timed_out_d;
            valid_q     <= valid_d;
        end
    end

    assign BUSY      = (state_q != IDLE);
    assign VALID     = valid_q;
    assign PERIOD    = period_q;
    assign HIGH_TIME = high_q;
    assign TIMED_OUT = timed_out_q;

endmodule
